// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
//
// Main control state machine of the multicycle RISC-V core. One shared ALU,
// one memory port and the register file are sequenced through fetch, decode,
// execute, memory and writeback steps. Every control output is a
// combinational function of the current state, Op, Zero and Mem_Ready; no
// output is registered.
//
// Ports:
//   clk         in   core clock, rising edge
//   rst         in   synchronous, active-high reset (forces Fetch, zeroes outputs)
//   Op[6:0]     in   opcode field from the instruction register
//   Zero        in   ALU zero flag (branch condition)
//   Mem_Ready   in   memory access completes this cycle
//   PC_Write    out  PC register enable
//   Adr_Src     out  memory address: 0 = PC, 1 = ALU result register
//   Mem_Write   out  memory write strobe
//   IR_Write    out  instruction register / OldPC enable
//   Result_Src  out  result mux: 00 ALUOut, 01 Data, 10 ALUResult
//   ALU_Src_A   out  ALU A: 00 PC, 01 OldPC, 10 rs1
//   ALU_Src_B   out  ALU B: 00 rs2, 01 Imm, 10 constant 4
//   ALU_Op      out  ALU decoder: 00 add, 01 subtract/compare, 10 funct fields
//   Reg_Write   out  register file write enable
//   Illegal_Op  out  one-cycle pulse when Decode sees an unsupported opcode
//   Instr_Done  out  one-cycle pulse on the last cycle of each instruction
// ---------------------------------------------------------------------------
module multicycle_control_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] Op,
  input  logic       Zero,
  input  logic       Mem_Ready,
  output logic       PC_Write,
  output logic       Adr_Src,
  output logic       Mem_Write,
  output logic       IR_Write,
  output logic [1:0] Result_Src,
  output logic [1:0] ALU_Src_A,
  output logic [1:0] ALU_Src_B,
  output logic [1:0] ALU_Op,
  output logic       Reg_Write,
  output logic       Illegal_Op,
  output logic       Instr_Done
);

  // Encoding of Fetch; fixed so the reset target is always state 0.
  localparam logic [3:0] RESET_STATE = 4'd0;

  // Supported opcodes.
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Mux-select encodings, named so the output table reads like the datapath.
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Encodings 11..15 are unused and recover to Fetch.
  typedef enum logic [3:0] {
    S_FETCH     = RESET_STATE,
    S_DECODE    = 4'd1,
    S_MEM_ADR   = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_JAL       = 4'd8,
    S_ALU_WB    = 4'd9,
    S_BEQ       = 4'd10
  } state_t;

  state_t state;
  state_t state_next;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // values from before the edge, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so that
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = S_FETCH;
    unique case (state)
      S_FETCH:     state_next = Mem_Ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Op)
          OP_LOAD,
          OP_STORE:  state_next = S_MEM_ADR;
          OP_RTYPE:  state_next = S_EXEC_R;
          OP_ITYPE:  state_next = S_EXEC_I;
          OP_JAL:    state_next = S_JAL;
          OP_BRANCH: state_next = S_BEQ;
          default:   state_next = S_FETCH;   // illegal opcode abandons the instruction
        endcase
      end
      // Anything reaching MemAdr that is not a load is a store.
      S_MEM_ADR:   state_next = (Op == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  state_next = Mem_Ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    state_next = S_FETCH;
      S_MEM_WRITE: state_next = Mem_Ready ? S_FETCH : S_MEM_WRITE;
      S_EXEC_R:    state_next = S_ALU_WB;
      S_EXEC_I:    state_next = S_ALU_WB;
      S_JAL:       state_next = S_ALU_WB;
      S_ALU_WB:    state_next = S_FETCH;
      S_BEQ:       state_next = S_FETCH;
      default:     state_next = S_FETCH;
    endcase
  end

  // Decode-time legality check, kept separate so the output table stays flat.
  logic op_supported;
  always_comb begin
    op_supported = 1'b0;
    case (Op)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_JAL, OP_BRANCH: op_supported = 1'b1;
      default: op_supported = 1'b0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic
  // -------------------------------------------------------------------------
  // Outputs are forced to zero while rst is high so write enables drop in the
  // same cycle reset is asserted, not one cycle later.
  always_comb begin
    PC_Write   = 1'b0;
    Adr_Src    = 1'b0;
    Mem_Write  = 1'b0;
    IR_Write   = 1'b0;
    Result_Src = RES_ALUOUT;
    ALU_Src_A  = SRCA_PC;
    ALU_Src_B  = SRCB_RS2;
    ALU_Op     = ALUOP_ADD;
    Reg_Write  = 1'b0;
    Illegal_Op = 1'b0;
    Instr_Done = 1'b0;

    if (!rst) begin
      unique case (state)
        S_FETCH: begin
          // PC+4 is computed every Fetch cycle; it only lands when memory is ready.
          Adr_Src    = 1'b0;
          ALU_Src_A  = SRCA_PC;
          ALU_Src_B  = SRCB_FOUR;
          ALU_Op     = ALUOP_ADD;
          Result_Src = RES_ALURES;
          IR_Write   = Mem_Ready;
          PC_Write   = Mem_Ready;
        end
        S_DECODE: begin
          // Branch target OldPC+Imm is computed speculatively into ALUOut.
          ALU_Src_A  = SRCA_OLDPC;
          ALU_Src_B  = SRCB_IMM;
          ALU_Op     = ALUOP_ADD;
          Illegal_Op = ~op_supported;
          Instr_Done = ~op_supported;
        end
        S_MEM_ADR: begin
          ALU_Src_A  = SRCA_RS1;
          ALU_Src_B  = SRCB_IMM;
          ALU_Op     = ALUOP_ADD;
        end
        S_MEM_READ: begin
          Adr_Src    = 1'b1;
          Result_Src = RES_ALUOUT;
        end
        S_MEM_WB: begin
          Result_Src = RES_DATA;
          Reg_Write  = 1'b1;
          Instr_Done = 1'b1;
        end
        S_MEM_WRITE: begin
          // The strobe is held for the whole stall; completion is Mem_Ready.
          Adr_Src    = 1'b1;
          Result_Src = RES_ALUOUT;
          Mem_Write  = 1'b1;
          Instr_Done = Mem_Ready;
        end
        S_EXEC_R: begin
          ALU_Src_A  = SRCA_RS1;
          ALU_Src_B  = SRCB_RS2;
          ALU_Op     = ALUOP_FUNCT;
        end
        S_EXEC_I: begin
          ALU_Src_A  = SRCA_RS1;
          ALU_Src_B  = SRCB_IMM;
          ALU_Op     = ALUOP_FUNCT;
        end
        S_JAL: begin
          // PC takes the target held in ALUOut while the ALU forms OldPC+4
          // for the link register write in ALUWB.
          ALU_Src_A  = SRCA_OLDPC;
          ALU_Src_B  = SRCB_FOUR;
          ALU_Op     = ALUOP_ADD;
          Result_Src = RES_ALUOUT;
          PC_Write   = 1'b1;
        end
        S_ALU_WB: begin
          Result_Src = RES_ALUOUT;
          Reg_Write  = 1'b1;
          Instr_Done = 1'b1;
        end
        S_BEQ: begin
          // rs1-rs2 sets Zero; the target computed in Decode is taken if equal.
          ALU_Src_A  = SRCA_RS1;
          ALU_Src_B  = SRCB_RS2;
          ALU_Op     = ALUOP_SUB;
          Result_Src = RES_ALUOUT;
          PC_Write   = Zero;
          Instr_Done = 1'b1;
        end
        default: begin
          // Unused encodings keep every output at its zero default.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_fsm
//
// Each scenario task queues per-cycle stimulus together with the expected
// output vector for that cycle, then replays the queue: stimulus is driven
// just after a rising edge and the outputs are compared at the falling edge.
// Expected vectors come from hand-written per-state tables below.
// Output vector order:
//   {PC_Write, Adr_Src, Mem_Write, IR_Write, Result_Src, ALU_Src_A,
//    ALU_Src_B, ALU_Op, Reg_Write, Illegal_Op, Instr_Done}
// ---------------------------------------------------------------------------
module tb_multicycle_control_fsm;

  logic       clk;
  logic       rst;
  logic [6:0] Op;
  logic       Zero;
  logic       Mem_Ready;
  logic       PC_Write;
  logic       Adr_Src;
  logic       Mem_Write;
  logic       IR_Write;
  logic [1:0] Result_Src;
  logic [1:0] ALU_Src_A;
  logic [1:0] ALU_Src_B;
  logic [1:0] ALU_Op;
  logic       Reg_Write;
  logic       Illegal_Op;
  logic       Instr_Done;

  multicycle_control_fsm dut (
    .clk        (clk),
    .rst        (rst),
    .Op         (Op),
    .Zero       (Zero),
    .Mem_Ready  (Mem_Ready),
    .PC_Write   (PC_Write),
    .Adr_Src    (Adr_Src),
    .Mem_Write  (Mem_Write),
    .IR_Write   (IR_Write),
    .Result_Src (Result_Src),
    .ALU_Src_A  (ALU_Src_A),
    .ALU_Src_B  (ALU_Src_B),
    .ALU_Op     (ALU_Op),
    .Reg_Write  (Reg_Write),
    .Illegal_Op (Illegal_Op),
    .Instr_Done (Instr_Done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [14:0] obs;
  assign obs = {PC_Write, Adr_Src, Mem_Write, IR_Write, Result_Src, ALU_Src_A,
                ALU_Src_B, ALU_Op, Reg_Write, Illegal_Op, Instr_Done};

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] ADD  = 7'b0110011;
  localparam logic [6:0] ADDI = 7'b0010011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] BAD  = 7'b1111111;

  typedef struct packed {
    logic       rst;
    logic [6:0] op;
    logic       zero;
    logic       mr;
  } stim_t;

  stim_t       stim_q[$];
  logic [14:0] exp_q[$];
  string       name_q[$];

  int passed = 0;
  int total  = 0;

  function automatic logic [14:0] ov(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic [1:0] rs,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [1:0] aop, input logic rw,
                                     input logic ill, input logic done);
    return {pcw, adr, mw, irw, rs, sa, sb, aop, rw, ill, done};
  endfunction

  // Expected output vector for each state.
  function automatic logic [14:0] e_reset();              return '0; endfunction
  function automatic logic [14:0] e_fetch(input logic mr); return ov(mr,0,0,mr,2'b10,2'b00,2'b10,2'b00,0,0,0); endfunction
  function automatic logic [14:0] e_decode();             return ov(0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,0,0); endfunction
  function automatic logic [14:0] e_decode_bad();         return ov(0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,1,1); endfunction
  function automatic logic [14:0] e_memadr();             return ov(0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,0,0); endfunction
  function automatic logic [14:0] e_memread();            return ov(0,1,0,0,2'b00,2'b00,2'b00,2'b00,0,0,0); endfunction
  function automatic logic [14:0] e_memwb();              return ov(0,0,0,0,2'b01,2'b00,2'b00,2'b00,1,0,1); endfunction
  function automatic logic [14:0] e_memwrite(input logic mr); return ov(0,1,1,0,2'b00,2'b00,2'b00,2'b00,0,0,mr); endfunction
  function automatic logic [14:0] e_execr();              return ov(0,0,0,0,2'b00,2'b10,2'b00,2'b10,0,0,0); endfunction
  function automatic logic [14:0] e_execi();              return ov(0,0,0,0,2'b00,2'b10,2'b01,2'b10,0,0,0); endfunction
  function automatic logic [14:0] e_jal();                return ov(1,0,0,0,2'b00,2'b01,2'b10,2'b00,0,0,0); endfunction
  function automatic logic [14:0] e_aluwb();              return ov(0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,0,1); endfunction
  function automatic logic [14:0] e_beq(input logic z);   return ov(z,0,0,0,2'b00,2'b10,2'b00,2'b01,0,0,1); endfunction

  function automatic stim_t st(input logic r, input logic [6:0] op, input logic z, input logic mr);
    stim_t s;
    s.rst = r; s.op = op; s.zero = z; s.mr = mr;
    return s;
  endfunction

  task automatic push(input stim_t s, input logic [14:0] e, input string n);
    stim_q.push_back(s);
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  // Pops one cycle of stimulus, drives it after the rising edge and returns
  // at the falling edge with the matching expectation.
  task automatic apply_next(output logic [14:0] e, output string n);
    stim_t s;
    s = stim_q.pop_front();
    e = exp_q.pop_front();
    n = name_q.pop_front();
    @(posedge clk);
    #1;
    rst = s.rst; Op = s.op; Zero = s.zero; Mem_Ready = s.mr;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [14:0] e; string n;
    for (int i = 0; i < 3; i++) push(st(1, ADD, 1, 1), e_reset(), "reset_hold");
    push(st(0, ADD, 0, 1), e_fetch(1), "reset_first_fetch");
    push(st(1, ADD, 0, 1), e_reset(), "reset_in_decode");
    while (exp_q.size() != 0) begin
      apply_next(e, n);
      total++;
      if (obs !== e) $display("FAIL %s: got %b expected %b", n, obs, e);
      else passed++;
    end
  endtask

  task automatic test_add();
    logic [14:0] e; string n;
    push(st(0, ADD, 0, 1), e_fetch(1), "add_fetch");
    push(st(0, ADD, 0, 1), e_decode(), "add_decode");
    push(st(0, BAD, 1, 0), e_execr(),  "add_execr_op_ignored");
    push(st(0, LW,  0, 0), e_aluwb(),  "add_aluwb");
    while (exp_q.size() != 0) begin
      apply_next(e, n);
      total++;
      if (obs !== e) $display("FAIL %s: got %b expected %b", n, obs, e);
      else passed++;
    end
  endtask

  task automatic test_lw();
    logic [14:0] e; string n;
    push(st(0, LW, 0, 0), e_fetch(0), "lw_fetch_stall");
    push(st(0, LW, 0, 1), e_fetch(1), "lw_fetch");
    push(st(0, LW, 0, 0), e_decode(), "lw_decode_ready_ignored");
    push(st(0, LW, 0, 0), e_memadr(), "lw_memadr");
    push(st(0, SW, 0, 0), e_memread(), "lw_memread_wait1");
    push(st(0, SW, 0, 0), e_memread(), "lw_memread_wait2");
    push(st(0, LW, 0, 1), e_memread(), "lw_memread_ready");
    push(st(0, LW, 0, 0), e_memwb(),   "lw_memwb");
    while (exp_q.size() != 0) begin
      apply_next(e, n);
      total++;
      if (obs !== e) $display("FAIL %s: got %b expected %b", n, obs, e);
      else passed++;
    end
  endtask

  task automatic test_sw();
    logic [14:0] e; string n;
    push(st(0, SW, 0, 1), e_fetch(1),     "sw_fetch");
    push(st(0, SW, 0, 1), e_decode(),     "sw_decode");
    push(st(0, SW, 0, 1), e_memadr(),     "sw_memadr");
    push(st(0, LW, 0, 0), e_memwrite(0),  "sw_memwrite_wait");
    push(st(0, LW, 0, 1), e_memwrite(1),  "sw_memwrite_done");
    while (exp_q.size() != 0) begin
      apply_next(e, n);
      total++;
      if (obs !== e) $display("FAIL %s: got %b expected %b", n, obs, e);
      else passed++;
    end
  endtask

  task automatic test_beq();
    logic [14:0] e; string n;
    push(st(0, BEQ, 0, 1), e_fetch(1), "beq_t_fetch");
    push(st(0, BEQ, 0, 1), e_decode(), "beq_t_decode");
    push(st(0, BEQ, 1, 1), e_beq(1),   "beq_taken");
    push(st(0, BEQ, 1, 1), e_fetch(1), "beq_n_fetch");
    push(st(0, BEQ, 1, 1), e_decode(), "beq_n_decode");
    push(st(0, BEQ, 0, 1), e_beq(0),   "beq_not_taken");
    while (exp_q.size() != 0) begin
      apply_next(e, n);
      total++;
      if (obs !== e) $display("FAIL %s: got %b expected %b", n, obs, e);
      else passed++;
    end
  endtask

  task automatic test_jal();
    logic [14:0] e; string n;
    push(st(0, JAL, 0, 1), e_fetch(1), "jal_fetch");
    push(st(0, JAL, 0, 1), e_decode(), "jal_decode");
    push(st(0, JAL, 0, 1), e_jal(),    "jal_jal");
    push(st(0, JAL, 0, 1), e_aluwb(),  "jal_aluwb");
    while (exp_q.size() != 0) begin
      apply_next(e, n);
      total++;
      if (obs !== e) $display("FAIL %s: got %b expected %b", n, obs, e);
      else passed++;
    end
  endtask

  task automatic test_illegal();
    logic [14:0] e; string n;
    push(st(0, BAD,     0, 1), e_fetch(1),     "ill_fetch");
    push(st(0, BAD,     1, 1), e_decode_bad(), "ill_decode_ff");
    push(st(0, BAD,     1, 1), e_fetch(1),     "ill_back_to_fetch");
    push(st(0, 7'h00,   0, 1), e_decode_bad(), "ill_decode_00");
    push(st(0, ADDI,    0, 1), e_fetch(1),     "ill_recover_fetch");
    push(st(0, ADDI,    0, 1), e_decode(),     "addi_decode");
    push(st(0, ADDI,    0, 1), e_execi(),      "addi_execi");
    push(st(0, ADDI,    0, 1), e_aluwb(),      "addi_aluwb");
    while (exp_q.size() != 0) begin
      apply_next(e, n);
      total++;
      if (obs !== e) $display("FAIL %s: got %b expected %b", n, obs, e);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    logic [14:0] e; string n;
    push(st(0, ADDI, 0, 1), e_fetch(1),    "rmid_i_fetch");
    push(st(0, ADDI, 0, 1), e_decode(),    "rmid_i_decode");
    push(st(1, ADDI, 0, 1), e_reset(),     "rmid_rst_in_execi");
    push(st(0, SW,   0, 0), e_fetch(0),    "rmid_fetch_after_execi");
    push(st(0, SW,   0, 1), e_fetch(1),    "rmid_s_fetch");
    push(st(0, SW,   0, 1), e_decode(),    "rmid_s_decode");
    push(st(0, SW,   0, 1), e_memadr(),    "rmid_s_memadr");
    push(st(0, SW,   0, 0), e_memwrite(0), "rmid_s_memwrite");
    push(st(1, SW,   0, 0), e_reset(),     "rmid_rst_in_memwrite");
    push(st(0, SW,   0, 1), e_fetch(1),    "rmid_fetch_after_memwrite");
    while (exp_q.size() != 0) begin
      apply_next(e, n);
      total++;
      if (obs !== e) $display("FAIL %s: got %b expected %b", n, obs, e);
      else passed++;
    end
  endtask

  initial begin
    rst = 1'b1; Op = '0; Zero = 1'b0; Mem_Ready = 1'b0;
    test_reset();
    test_add();
    test_lw();
    test_sw();
    test_beq();
    test_jal();
    test_illegal();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Guard against a hung run; every scenario is a fixed number of cycles.
  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", passed, total);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Main control state machine for the multicycle RISC-V core. It sequences one shared ALU, memory port and register file across the fetch, decode, execute, memory and writeback steps of each instruction. It drives ALU_Op into the existing ALU decoder, and drives the datapath mux selects and write enables. A memory-ready handshake stalls it, and it flags opcodes it does not support.

Parameters:
- RESET_STATE, 4'd0, encoding of the Fetch state; fixed, never overridden.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  synchronous, active-high reset
- Op  in  7  opcode field from the instruction register
- Zero  in  1  ALU zero flag
- Mem_Ready  in  1  memory access completes this cycle
- PC_Write  out  1  PC register enable
- Adr_Src  out  1  memory address select: 0 = PC, 1 = ALU result register
- Mem_Write  out  1  memory write strobe
- IR_Write  out  1  instruction register and OldPC enable
- Result_Src  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALU_Src_A  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1 register
- ALU_Src_B  out  2  ALU B select: 00 = rs2 register, 01 = Imm, 10 = constant 4
- ALU_Op  out  2  input to the ALU decoder: 00 = add, 01 = subtract/compare, 10 = use funct fields
- Reg_Write  out  1  register file write enable
- Illegal_Op  out  1  one-cycle pulse on an unsupported opcode
- Instr_Done  out  1  one-cycle pulse on the last cycle of each instruction

Behaviour:
- State register: 4 bits, updated on the rising clk edge. rst=1 forces the next state to Fetch.
- While rst=1, every output is 0.
- First cycle after rst falls: state is Fetch.
- Outputs are combinational from the current state plus Mem_Ready, Zero and Op. Registered flags: none.
- Unlisted outputs are 0 in every state.

States and outputs:
- Fetch: Adr_Src=0, ALU_Src_A=00, ALU_Src_B=10, ALU_Op=00, Result_Src=10. IR_Write = PC_Write = Mem_Ready. Stays in Fetch while Mem_Ready=0; goes to Decode when Mem_Ready=1.
- Decode: ALU_Src_A=01, ALU_Src_B=01, ALU_Op=00 (computes the branch target). Next state by Op:
  - 0000011 or 0100011 -> MemAdr
  - 0110011 -> ExecuteR
  - 0010011 -> ExecuteI
  - 1101111 -> JAL
  - 1100011 -> BEQ
  - any other value -> Fetch, with Illegal_Op=1 and Instr_Done=1 for that cycle.
- MemAdr: ALU_Src_A=10, ALU_Src_B=01, ALU_Op=00. Op=0000011 -> MemRead; otherwise -> MemWrite.
- MemRead: Adr_Src=1, Result_Src=00. Holds until Mem_Ready=1, then -> MemWB.
- MemWB: Result_Src=01, Reg_Write=1, Instr_Done=1. -> Fetch.
- MemWrite: Adr_Src=1, Result_Src=00, Mem_Write=1 on every cycle spent in the state. Holds until Mem_Ready=1; in that cycle Instr_Done=1, then -> Fetch.
- ExecuteR: ALU_Src_A=10, ALU_Src_B=00, ALU_Op=10. -> ALUWB.
- ExecuteI: ALU_Src_A=10, ALU_Src_B=01, ALU_Op=10. -> ALUWB.
- JAL: ALU_Src_A=01, ALU_Src_B=10, ALU_Op=00, Result_Src=00, PC_Write=1. -> ALUWB.
- ALUWB: Result_Src=00, Reg_Write=1, Instr_Done=1. -> Fetch.
- BEQ: ALU_Src_A=10, ALU_Src_B=00, ALU_Op=01, Result_Src=00, PC_Write=Zero, Instr_Done=1. -> Fetch.

Boundary conditions:
- Unused state encodings (11-15) -> Fetch on the next edge, with all outputs 0 while in them.
- rst asserted mid-instruction: the write enables drop in the same cycle, and the state is Fetch after the edge.
- Op is sampled only in Decode and MemAdr; changes to Op in other states are ignored.
- Mem_Ready is ignored outside Fetch, MemRead and MemWrite.

Latency with Mem_Ready tied high, counting cycles from entering Fetch:
- lw: 5
- sw: 4
- R-type, I-type ALU, jal: 4
- beq: 3
- illegal opcode: 2

Test Plan:
- rst=1 for 3 cycles, then released, Mem_Ready=1 -> all outputs 0 during reset; cycle 1 after release is Fetch with IR_Write=1, PC_Write=1, ALU_Src_B=10.
- Op=0110011 (add), Mem_Ready=1 -> state sequence Fetch, Decode, ExecuteR (ALU_Op=10), ALUWB (Reg_Write=1, Instr_Done=1), Fetch; 4 cycles.
- Op=0000011 (lw), Mem_Ready held 0 for 2 cycles in MemRead -> MemRead lasts 3 cycles with Adr_Src=1; MemWB asserts Reg_Write=1 with Result_Src=01; total 7 cycles.
- Op=0100011 (sw), Mem_Ready=0 for 1 cycle in MemWrite -> Mem_Write=1 for 2 consecutive cycles; Instr_Done pulses once; Reg_Write never asserted.
- Op=1100011 with Zero=1, then again with Zero=0 -> BEQ shows ALU_Op=01; PC_Write=1 in the first case and 0 in the second; each instruction takes 3 cycles.
- Op=1111111 -> Decode asserts Illegal_Op=1 for exactly one cycle, returns to Fetch; Reg_Write, Mem_Write and PC_Write (outside Fetch) stay 0; rst asserted in ExecuteI -> Fetch on the next cycle.
